// File: rtl/pipe_skid_reg.sv
// Two-entry elastic register (main + skid): 1-cycle latency, full throughput.
// in_ready/out_valid come from state registers only, so out_ready never reaches in_ready combinationally.
module pipe_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // Encoding equals the occupancy, so count is the state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_move_skid;

    always_comb begin
        w_next      = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_move_skid = 1'b0;
        if (flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (in_valid) begin
                        w_next      = BUSY;
                        w_load_main = 1'b1;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        w_load_main = 1'b1;
                    end else if (in_valid) begin
                        w_load_skid = 1'b1;
                        w_next      = FULL;
                    end else if (out_ready) begin
                        w_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        w_move_skid = 1'b1;
                        w_next      = BUSY;
                    end
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    // Payload registers move only on an accepted input or a skid-to-main shift.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= in_data;
            end else if (w_move_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign count     = r_state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised traffic into pipe_skid_reg with a queue scoreboard checked at the falling edge.
module tb_pipe_skid_reg;

    logic        clk;
    logic        clrn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q[$];
    logic [31:0] out_log[$];

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Asynchronous reset empties the reference model immediately.
    always @(negedge clrn) q.delete();

    // Monitor: compare DUT against the reference queue, then apply the transfers of the coming edge.
    always @(negedge clk) begin
        if (!clrn) begin
            q.delete();
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_count", {30'd0, count}, 32'd0);
            chk("rst_out_data", out_data, 32'd0);
        end else begin
            automatic int  sz   = q.size();
            automatic bit  full = (sz == 2);
            chk("count", {30'd0, count}, sz);
            chk("in_ready", {31'd0, in_ready}, {31'd0, (sz != 2)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, (sz != 0)});
            if (sz > 0) chk("out_data", out_data, q[0]);
            if (sz > 0 && out_ready) out_log.push_back(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && !full) q.push_back(in_data);
        end
    end

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_log(input string nm, input int n, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2);
        logic [31:0] e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        chk({nm, "_len"}, out_log.size(), n);
        for (int i = 0; i < n && i < out_log.size(); i++) chk({nm, "_order"}, out_log[i], e[i]);
        out_log.delete();
    endtask

    initial begin
        clrn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #2;

        // Reset held with an offer pending, then first edge after release loads it.
        repeat (3) drive(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        clrn = 1'b1;
        drive(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        chk("rel_count", {30'd0, count}, 32'd1);
        chk("rel_out_data", out_data, 32'hA5A5A5A5);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk_log("reset_release", 1, 32'hA5A5A5A5, 32'h0, 32'h0);

        // Streaming at full rate.
        drive(1'b1, 32'd1, 1'b1, 1'b0);
        chk("stream_first", out_data, 32'd1);
        drive(1'b1, 32'd2, 1'b1, 1'b0);
        drive(1'b1, 32'd3, 1'b1, 1'b0);
        drive(1'b1, 32'd4, 1'b1, 1'b0);
        chk("stream_count", {30'd0, count}, 32'd1);
        chk("stream_last", out_data, 32'd4);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        if (out_log.size() == 4) begin
            chk("stream_d0", out_log[0], 32'd1);
            out_log.delete(0);
        end
        chk_log("stream", 3, 32'd2, 32'd3, 32'd4);

        // Backpressure: fill, hold third offer, then drain.
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        chk("bp_count", {30'd0, count}, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_head", out_data, 32'h11);
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        drive(1'b1, 32'h33, 1'b1, 1'b0);
        drive(1'b1, 32'h33, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk_log("backpressure", 3, 32'h11, 32'h22, 32'h33);

        // Flush from FULL with a concurrent offer.
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        drive(1'b1, 32'h99, 1'b0, 1'b1);
        chk("flush_count", {30'd0, count}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk_log("flush_full", 0, 32'h0, 32'h0, 32'h0);

        // Flush while the head is consumed: head counts as delivered, offer dropped.
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        drive(1'b1, 32'h66, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk_log("flush_consume", 1, 32'h55, 32'h0, 32'h0);

        // Asynchronous reset pulse between edges while FULL.
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        #1 clrn = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_count", {30'd0, count}, 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        #1 clrn = 1'b1;
        drive(1'b1, 32'h77, 1'b1, 1'b0);
        chk("arst_restart", out_data, 32'h77);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk_log("arst", 1, 32'h77, 32'h0, 32'h0);

        // Randomised traffic against the reference queue.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 99) < 5));
        end
        out_log.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
